// File: rtl/bus_pkg.sv
// Transfer types shared by every slave on the register bus.
// Pure type definitions; no logic.
package bus_pkg;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } ttype_e;

endpackage

// File: rtl/clint_pkg.sv
// CLINT register map, prescaler width and per-hart write-enable bundle.
// Pure declarations; no logic.
package clint_pkg;

  localparam logic [27:0] MSIP_BASE     = 28'h200_0000;
  localparam logic [27:0] MTIMECMP_BASE = 28'h200_4000;
  localparam logic [27:0] MTIME_LO      = 28'h200_BFF8;
  localparam logic [27:0] MTIME_HI      = 28'h200_BFFC;
  localparam int unsigned TICK_W        = 16;

  typedef struct packed {
    logic msip;
    logic cmp_lo;
    logic cmp_hi;
  } hart_we_t;

  function automatic logic [27:0] msip_addr(input int unsigned h);
    return MSIP_BASE + 28'(h << 2);
  endfunction

  function automatic logic [27:0] cmp_addr(input int unsigned h);
    return MTIMECMP_BASE + 28'(h << 3);
  endfunction

endpackage

// File: rtl/slave_bus_if.sv
// Single-cycle register bus: master presents addr/wdata/ss/ttype, slave answers rdata/bdone.
// No backpressure beyond bdone.
interface slave_bus_if;
  import bus_pkg::*;

  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ss;
  ttype_e      ttype;
  logic        bdone;

  modport slave  (input addr, wdata, ss, ttype, output rdata, bdone);
  modport master (output addr, wdata, ss, ttype, input rdata, bdone);

endinterface

// File: rtl/clint_hart.sv
// Per-hart CLINT state: msip bit, 64-bit mtimecmp and the registered timer compare.
// irq_timer lags the compared registers by one cycle; writes always accepted.
module clint_hart
  import clint_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  hart_we_t    we,
  input  logic [31:0] wdata,
  input  logic [63:0] mtime,
  output logic        msip,
  output logic [63:0] mtimecmp,
  output logic        irq_timer
);

  logic        msip_q, msip_d;
  logic [63:0] cmp_q, cmp_d;
  logic        irq_timer_q, irq_timer_d;

  always_comb begin
    msip_d      = msip_q;
    cmp_d       = cmp_q;
    // Compare uses pre-edge mtime and mtimecmp, so a write shows up one cycle later.
    irq_timer_d = (mtime >= cmp_q);
    if (we.msip)   msip_d        = wdata[0];
    if (we.cmp_lo) cmp_d[31:0]   = wdata;
    if (we.cmp_hi) cmp_d[63:32]  = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msip_q      <= 1'b0;
      cmp_q       <= '1;
      irq_timer_q <= 1'b0;
    end else begin
      msip_q      <= msip_d;
      cmp_q       <= cmp_d;
      irq_timer_q <= irq_timer_d;
    end
  end

  assign msip      = msip_q;
  assign mtimecmp  = cmp_q;
  assign irq_timer = irq_timer_q;

endmodule

// File: rtl/clint_multi.sv
// Multi-hart CLINT: prescaled 64-bit mtime, address decode and per-hart msip/mtimecmp.
// Reads and writes complete in the cycle presented (bdone tied high); irq_timer is registered.
module clint_multi
  import clint_pkg::*;
  import bus_pkg::*;
#(
  parameter int unsigned NHARTS   = 1,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  slave_bus_if.slave        bus,
  output logic [NHARTS-1:0] irq_sw,
  output logic [NHARTS-1:0] irq_timer
);

  localparam logic [TICK_W-1:0] PRESC_MAX = TICK_W'(TICK_DIV - 1);

  logic [27:0]       addr;
  logic              wr;
  logic              unused_addr_hi;
  logic [TICK_W-1:0] presc_q, presc_d;
  logic [63:0]       mtime_q, mtime_d;
  logic [NHARTS-1:0] msip;
  logic [63:0]       mtimecmp [NHARTS];
  hart_we_t          hart_we  [NHARTS];

  assign addr           = bus.addr[27:0];
  assign unused_addr_hi = ^bus.addr[31:28];
  assign wr             = bus.ss && (bus.ttype == WRITE);
  assign bus.bdone      = 1'b1;

  always_comb begin
    presc_d = presc_q + 1'b1;
    mtime_d = mtime_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      mtime_d = mtime_q + 64'd1;
    end
    // A software write wins over the tick and restarts the prescaler phase.
    if (wr && (addr == MTIME_LO)) begin
      mtime_d = {mtime_q[63:32], bus.wdata};
      presc_d = '0;
    end else if (wr && (addr == MTIME_HI)) begin
      mtime_d = {bus.wdata, mtime_q[31:0]};
      presc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      mtime_q <= '0;
    end else begin
      presc_q <= presc_d;
      mtime_q <= mtime_d;
    end
  end

  always_comb begin
    for (int unsigned h = 0; h < NHARTS; h++) begin
      hart_we[h].msip   = wr && (addr == msip_addr(h));
      hart_we[h].cmp_lo = wr && (addr == cmp_addr(h));
      hart_we[h].cmp_hi = wr && (addr == cmp_addr(h) + 28'd4);
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (addr == MTIME_LO) bus.rdata = mtime_q[31:0];
    if (addr == MTIME_HI) bus.rdata = mtime_q[63:32];
    for (int unsigned h = 0; h < NHARTS; h++) begin
      if (addr == msip_addr(h))         bus.rdata = {31'b0, msip[h]};
      if (addr == cmp_addr(h))          bus.rdata = mtimecmp[h][31:0];
      if (addr == cmp_addr(h) + 28'd4)  bus.rdata = mtimecmp[h][63:32];
    end
  end

  for (genvar g = 0; g < NHARTS; g++) begin : g_hart
    clint_hart u_hart (
      .clk       (clk),
      .rst_n     (rst_n),
      .we        (hart_we[g]),
      .wdata     (bus.wdata),
      .mtime     (mtime_q),
      .msip      (msip[g]),
      .mtimecmp  (mtimecmp[g]),
      .irq_timer (irq_timer[g])
    );
  end

  assign irq_sw = msip;

endmodule

// File: tb/tb_clint_multi.sv
// Bench for clint_multi: two instances (TICK_DIV=1 and TICK_DIV=4, both two harts)
// checked against an arithmetic model of mtime and the register file.
module tb_clint_multi;
  import bus_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  ttype_e      ttype = READ;
  logic        ss_a  = 1'b0;
  logic        ss_b  = 1'b0;
  logic [1:0]  irq_sw_a, irq_timer_a, irq_sw_b, irq_timer_b;

  slave_bus_if bus_a ();
  slave_bus_if bus_b ();
  assign bus_a.addr  = addr;
  assign bus_a.wdata = wdata;
  assign bus_a.ttype = ttype;
  assign bus_a.ss    = ss_a;
  assign bus_b.addr  = addr;
  assign bus_b.wdata = wdata;
  assign bus_b.ttype = ttype;
  assign bus_b.ss    = ss_b;

  clint_multi #(.NHARTS(2), .TICK_DIV(1)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .irq_sw(irq_sw_a), .irq_timer(irq_timer_a));
  clint_multi #(.NHARTS(2), .TICK_DIV(4)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .irq_sw(irq_sw_b), .irq_timer(irq_timer_b));

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Model: mtime = anchor value + elapsed edges / divider; registers as plain arrays.
  int unsigned      cyc = 0;
  logic [63:0]      anchor_val [2];
  int unsigned      anchor_cyc [2];
  logic [63:0]      m_cmp [2][2];
  logic [1:0][1:0]  m_msip;
  logic [1:0][1:0]  exp_irq;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int unsigned tdiv(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic logic [63:0] mt_now(input int d);
    return anchor_val[d] + 64'((cyc - anchor_cyc[d]) / tdiv(d));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_irq <= '0;
    else
      for (int d = 0; d < 2; d++)
        for (int h = 0; h < 2; h++)
          exp_irq[d][h] <= (mt_now(d) >= m_cmp[d][h]);
  end

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      anchor_val[d] = '0;
      anchor_cyc[d] = cyc;
      m_cmp[d][0]   = '1;
      m_cmp[d][1]   = '1;
    end
    m_msip = '0;
  endfunction

  function automatic logic [31:0] model_read(input int d, input logic [31:0] a);
    logic [27:0] o;
    logic [63:0] t;
    int h;
    o = a[27:0];
    t = mt_now(d);
    if (o == 28'h200BFF8) return t[31:0];
    if (o == 28'h200BFFC) return t[63:32];
    if (o >= 28'h2000000 && o < 28'h2000008 && o[1:0] == 2'b00) begin
      h = int'((o - 28'h2000000) >> 2);
      return {31'b0, m_msip[d][h]};
    end
    if (o >= 28'h2004000 && o < 28'h2004010 && o[1:0] == 2'b00) begin
      h = int'((o - 28'h2004000) >> 3);
      return o[2] ? m_cmp[d][h][63:32] : m_cmp[d][h][31:0];
    end
    return 32'h0;
  endfunction

  function automatic void model_write(input int d, input logic [31:0] a,
                                      input logic [31:0] v, input logic [63:0] pre);
    logic [27:0] o;
    int h;
    o = a[27:0];
    if (o == 28'h200BFF8) begin
      anchor_val[d] = {pre[63:32], v};
      anchor_cyc[d] = cyc;
    end else if (o == 28'h200BFFC) begin
      anchor_val[d] = {v, pre[31:0]};
      anchor_cyc[d] = cyc;
    end else if (o >= 28'h2000000 && o < 28'h2000008 && o[1:0] == 2'b00) begin
      h = int'((o - 28'h2000000) >> 2);
      m_msip[d][h] = v[0];
    end else if (o >= 28'h2004000 && o < 28'h2004010 && o[1:0] == 2'b00) begin
      h = int'((o - 28'h2004000) >> 3);
      if (o[2]) m_cmp[d][h][63:32] = v;
      else      m_cmp[d][h][31:0]  = v;
    end
  endfunction

  // Called at a negedge; the write lands on the next posedge; returns at the following negedge.
  task automatic bus_write(input int d, input logic [31:0] a, input logic [31:0] v);
    logic [63:0] pre;
    pre   = mt_now(d);
    addr  = a;
    wdata = v;
    ttype = WRITE;
    if (d == 0) ss_a = 1'b1; else ss_b = 1'b1;
    @(posedge clk);
    #1;
    ss_a  = 1'b0;
    ss_b  = 1'b0;
    ttype = READ;
    model_write(d, a, v, pre);
    @(negedge clk);
  endtask

  task automatic bus_read(input int d, input logic [31:0] a, output logic [31:0] rd);
    addr  = a;
    ttype = READ;
    if (d == 0) ss_a = 1'b1; else ss_b = 1'b1;
    #1;
    rd   = (d == 0) ? bus_a.rdata : bus_b.rdata;
    ss_a = 1'b0;
    ss_b = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (irq_sw_a !== 2'b00 || irq_timer_a !== 2'b00 || irq_sw_b !== 2'b00 || irq_timer_b !== 2'b00) begin
      failures++;
      $display("FAIL reset_irq: a_sw=%b a_tmr=%b b_sw=%b b_tmr=%b required all 0",
               irq_sw_a, irq_timer_a, irq_sw_b, irq_timer_b);
    end
    bus_read(0, 32'h0200_BFF8, rd);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL reset_mtime: got %h required 0", rd); end
    bus_read(1, 32'h0200_4004, rd);
    checks++;
    if (rd !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_cmp: got %h required ffffffff", rd); end
    rst_n = 1'b1;
    anchor_cyc[0] = cyc;
    anchor_cyc[1] = cyc;
  endtask

  task automatic test_count_div1();
    logic [31:0] rd;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      bus_read(0, 32'h0200_BFF8, rd);
      checks++;
      if (rd !== 32'(i)) begin failures++; $display("FAIL count_div1: got %0d required %0d", rd, i); end
      checks++;
      if (irq_timer_a !== 2'b00) begin failures++; $display("FAIL count_irq: got %b required 00", irq_timer_a); end
    end
  endtask

  task automatic test_prescaler();
    logic [31:0] rd;
    logic [63:0] t;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus_read(1, 32'h0200_BFF8, rd);
      t = mt_now(1);
      checks++;
      if (rd !== t[31:0]) begin failures++; $display("FAIL presc_track: got %h required %h", rd, t[31:0]); end
    end
    // Write mid-phase so the clear of the prescaler is observable.
    while (((cyc - anchor_cyc[1]) % 4) != 2) @(negedge clk);
    bus_write(1, 32'h0200_BFF8, 32'h10);
    for (int k = 0; k <= 4; k++) begin
      bus_read(1, 32'h0200_BFF8, rd);
      checks++;
      if (rd !== ((k < 4) ? 32'h10 : 32'h11)) begin
        failures++;
        $display("FAIL presc_after_write: edge %0d got %h required %h", k, rd, (k < 4) ? 32'h10 : 32'h11);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_carry();
    logic [31:0] rd;
    bus_write(0, 32'h0200_BFF8, 32'hFFFF_FFFE);
    bus_write(0, 32'h0200_BFFC, 32'h0);
    repeat (2) @(negedge clk);
    bus_read(0, 32'h0200_BFFC, rd);
    checks++;
    if (rd !== 32'h1) begin failures++; $display("FAIL carry_hi: got %h required 1", rd); end
    bus_read(0, 32'h0200_BFF8, rd);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL carry_lo: got %h required 0", rd); end
  endtask

  task automatic test_timer_irq();
    logic [31:0] rd;
    bit seen;
    bus_write(0, 32'h0200_400C, 32'h0);
    bus_write(0, 32'h0200_4008, 32'd100);
    bus_write(0, 32'h0200_BFFC, 32'h0);
    bus_write(0, 32'h0200_BFF8, 32'd90);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      bus_read(0, 32'h0200_BFF8, rd);
      checks++;
      if (irq_timer_a !== exp_irq[0]) begin
        failures++; $display("FAIL irq_track: got %b required %b", irq_timer_a, exp_irq[0]);
      end
      if (rd == 32'd100) begin
        seen = 1'b1;
        checks++;
        if (irq_timer_a !== 2'b00) begin failures++; $display("FAIL irq_at_100: got %b required 00", irq_timer_a); end
        @(negedge clk);
        checks++;
        if (irq_timer_a !== 2'b10) begin failures++; $display("FAIL irq_rise: got %b required 10", irq_timer_a); end
      end else begin
        @(negedge clk);
      end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL irq_timeout: mtime never read 100, last %0d", rd); end
    bus_write(0, 32'h0200_400C, 32'h1);
    checks++;
    if (irq_timer_a !== 2'b10) begin failures++; $display("FAIL irq_hold: got %b required 10", irq_timer_a); end
    @(negedge clk);
    checks++;
    if (irq_timer_a !== 2'b00) begin failures++; $display("FAIL irq_clear: got %b required 00", irq_timer_a); end
  endtask

  task automatic test_msip();
    logic [31:0] rd;
    bus_write(0, 32'h0200_0004, 32'hFFFF_FFFF);
    checks++;
    if (irq_sw_a !== 2'b10) begin failures++; $display("FAIL msip_irq: got %b required 10", irq_sw_a); end
    bus_read(0, 32'h0200_0004, rd);
    checks++;
    if (rd !== 32'h1) begin failures++; $display("FAIL msip_read: got %h required 1", rd); end
    bus_write(0, 32'h0200_0008, 32'h1);
    bus_read(0, 32'h0200_0008, rd);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL msip_oob_read: got %h required 0", rd); end
    checks++;
    if (irq_sw_a !== 2'b10 || bus_a.bdone !== 1'b1) begin
      failures++; $display("FAIL msip_oob_write: sw=%b bdone=%b required 10/1", irq_sw_a, bus_a.bdone);
    end
  endtask

  task automatic test_random();
    logic [31:0] tbl [12];
    logic [31:0] a, v, rd, exp_rd;
    logic [63:0] t;
    int d;
    tbl = '{32'h0200_BFF8, 32'h0200_BFFC, 32'h0200_4000, 32'h0200_4004,
            32'h0200_4008, 32'h0200_400C, 32'h0200_0000, 32'h0200_0004,
            32'h0200_0008, 32'h0200_4010, 32'h0200_BFF4, 32'h0200_0002};
    for (int it = 0; it < 300; it++) begin
      checks++;
      if (irq_sw_a !== m_msip[0] || irq_timer_a !== exp_irq[0] ||
          irq_sw_b !== m_msip[1] || irq_timer_b !== exp_irq[1]) begin
        failures++;
        $display("FAIL rand_irq it=%0d: a=%b/%b b=%b/%b required a=%b/%b b=%b/%b", it,
                 irq_sw_a, irq_timer_a, irq_sw_b, irq_timer_b, m_msip[0], exp_irq[0], m_msip[1], exp_irq[1]);
      end
      d = int'($urandom_range(0, 1));
      a = tbl[$urandom_range(0, 11)];
      a[31:28] = 4'($urandom);
      bus_read(d, a, rd);
      exp_rd = model_read(d, a);
      checks++;
      if (rd !== exp_rd) begin
        failures++; $display("FAIL rand_read d=%0d addr=%h: got %h required %h", d, a, rd, exp_rd);
      end
      if ($urandom_range(0, 1) == 1) begin
        d = int'($urandom_range(0, 1));
        a = tbl[$urandom_range(0, 11)];
        t = mt_now(d);
        case (a[27:0])
          28'h200BFF8, 28'h2004000, 28'h2004008: v = t[31:0] + 32'($urandom_range(0, 24)) - 32'd8;
          28'h200BFFC, 28'h2004004, 28'h200400C: v = t[63:32] + 32'($urandom_range(0, 1));
          default: v = $urandom;
        endcase
        a[31:28] = 4'($urandom);
        bus_write(d, a, v);
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    bus_write(0, 32'h0200_0004, 32'h0);
    bus_write(0, 32'h0200_0000, 32'h1);
    bus_write(0, 32'h0200_4004, 32'h0);
    bus_write(0, 32'h0200_4000, 32'h0);
    @(negedge clk);
    checks++;
    if (irq_timer_a[0] !== 1'b1 || irq_sw_a[0] !== 1'b1) begin
      failures++; $display("FAIL premid_irq: tmr=%b sw=%b required bit0 set", irq_timer_a, irq_sw_a);
    end
    // Reset lands mid-cycle while a write to msip[1] is being presented.
    addr  = 32'h0200_0004;
    wdata = 32'h1;
    ttype = WRITE;
    ss_a  = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (irq_sw_a !== 2'b00 || irq_timer_a !== 2'b00 || irq_sw_b !== 2'b00 || irq_timer_b !== 2'b00) begin
      failures++;
      $display("FAIL mid_reset_irq: a_sw=%b a_tmr=%b b_sw=%b b_tmr=%b required all 0",
               irq_sw_a, irq_timer_a, irq_sw_b, irq_timer_b);
    end
    ss_a  = 1'b0;
    ttype = READ;
    model_reset();
    @(negedge clk);
    bus_read(0, 32'h0200_4000, rd);
    checks++;
    if (rd !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mid_reset_cmp_lo: got %h required ffffffff", rd); end
    bus_read(0, 32'h0200_4004, rd);
    checks++;
    if (rd !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mid_reset_cmp_hi: got %h required ffffffff", rd); end
    rst_n = 1'b1;
    anchor_cyc[0] = cyc;
    anchor_cyc[1] = cyc;
    repeat (2) @(negedge clk);
    bus_read(0, 32'h0200_BFF8, rd);
    checks++;
    if (rd !== 32'd2) begin failures++; $display("FAIL mid_reset_restart: got %0d required 2", rd); end
    bus_read(0, 32'h0200_0004, rd);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL mid_reset_abandon: got %h required 0", rd); end
  endtask

  initial begin
    test_reset();
    test_count_div1();
    test_prescaler();
    test_carry();
    test_timer_irq();
    test_msip();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clint_multi.md
CLINT_MULTI -- requirements
Module: clint_multi

Interface
REQ-001 SHALL have parameter NHARTS, default 1, number of harts served, legal range 1..8.
REQ-002 SHALL have parameter TICK_DIV, default 1, clk cycles per mtime increment, legal range 1..65535.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port bus  slave_bus_if.slave  --  register access (addr, wdata, rdata, ss, ttype, bdone).
REQ-006 SHALL have port irq_sw  output  NHARTS  software interrupt per hart, bit h = msip[h][0].
REQ-007 SHALL have port irq_timer  output  NHARTS  timer interrupt per hart, registered.

Function
REQ-008 SHALL decode bus.addr[27:0] only: msip[h] at 0x2000000+4h; mtimecmp[h] low word at 0x2004000+8h, high word at +4; mtime low word at 0x200BFF8, high word at 0x200BFFC.
REQ-009 SHALL assert bus.bdone = 1 combinationally in every cycle, giving single-cycle reads and writes.
REQ-010 SHALL drive bus.rdata combinationally from the decoded register; unmapped offsets and harts >= NHARTS read 0.
REQ-011 SHALL make msip[h] 1 bit wide; reads return {31'b0, msip[h]}; writes store wdata[0].
REQ-012 SHALL hold mtime as 64 bits and mtimecmp[h] as 64 bits each.
REQ-013 SHALL run a prescaler 0..TICK_DIV-1; when it reaches TICK_DIV-1 it wraps to 0 and mtime increments by 1 with full 64-bit carry; with TICK_DIV=1, mtime increments every cycle.
REQ-014 SHALL wrap mtime from 0xFFFF_FFFF_FFFF_FFFF to 0 with no flag.
REQ-015 SHALL make mtime writable per 32-bit half; when bus.ss && ttype==WRITE hits either half, the written half takes wdata, the other half holds, the cycle's increment is suppressed, and the prescaler clears to 0.
REQ-016 SHALL make a write to one mtimecmp half replace that half only.
REQ-017 SHALL register irq_timer[h] <= (mtime >= mtimecmp[h]), unsigned 64-bit, using register values before the current edge; one-cycle latency from the register change.
REQ-018 SHALL make a same-cycle write and increment resolve to the write, and a read in the same cycle return the pre-edge value.
REQ-019 SHALL ignore writes to unmapped offsets without side effects.

Reset
REQ-020 SHALL asynchronously on rst_n low: mtime=0, prescaler=0, mtimecmp[h]=0xFFFF_FFFF_FFFF_FFFF, msip[h]=0, irq_timer=0, irq_sw=0.
REQ-021 SHALL abandon any in-flight access when reset asserts mid-operation, with no partial update surviving.
REQ-022 SHALL start counting on the first rising clk edge after rst_n deasserts.

Structure
REQ-023 SHALL place the register offsets (MSIP_BASE, MTIMECMP_BASE, MTIME_LO, MTIME_HI) and the TICK_DIV width constant in shared package clint_pkg; ttype/WRITE come from the existing bus package.
REQ-024 SHALL instantiate sub-module clint_hart once per hart via generate; it holds msip, mtimecmp and the irq_timer flop, and receives mtime plus decoded write enables.
REQ-025 SHALL keep mtime, the prescaler and the address decode in clint_multi.

Verification
REQ-026 Bench SHALL check reset release with TICK_DIV=1 -> mtime reads 1,2,3 on consecutive cycles; irq_timer=0 throughout.
REQ-027 Bench SHALL check TICK_DIV=4 -> mtime advances once per 4 clk; after writing mtime low=0x10 the next increment occurs exactly 4 cycles later.
REQ-028 Bench SHALL check writing mtime low=0xFFFF_FFFE, high=0 -> after 2 ticks, mtime high reads 1 and low reads 0.
REQ-029 Bench SHALL check NHARTS=2, writing mtimecmp[1]={0,100} -> irq_timer[1] rises on the cycle after mtime reaches 100; irq_timer[0] stays 0; writing high=1 clears it one cycle later.
REQ-030 Bench SHALL check writing msip[1]=0xFFFF_FFFF -> irq_sw=2'b10 and a read returns 1; a read of 0x2000008 with NHARTS=2 returns 0.
REQ-031 Bench SHALL check asserting rst_n low mid-count with irq_timer high -> all outputs 0 immediately (asynchronously) and mtimecmp reads all-ones.
